system_bus_arbiter: RTL

SYSTEM_BUS_ARBITER -- requirements
Module: system_bus_arbiter

---
 rtl/system_bus_arbiter_pkg.sv | 13 +
 rtl/system_bus_arbiter_picker.sv | 31 +++
 rtl/system_bus_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/system_bus_arbiter_pkg.sv
// Shared constants for the system bus arbiter: FSM encoding, grant index
// width and the data word returned to a master whose transaction timed out.
package system_bus_arbiter_pkg;

  localparam int          GID_W         = 3;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/system_bus_arbiter_picker.sv
// Combinational round-robin picker: the requester closest above last_grant
// (wrapping) wins.
module rr_priority_picker
  import system_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [GID_W-1:0]       last_grant,
  output logic [GID_W-1:0]       winner,
  output logic                   any_req
);

  always_comb begin
    int best_d;
    int d;
    best_d  = NUM_MASTERS;
    d       = 0;
    winner  = '0;
    any_req = |req;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      // distance of candidate i from the slot after last_grant
      d = (i + 2 * NUM_MASTERS - 1 - int'(last_grant)) % NUM_MASTERS;
      if (req[i] && d < best_d) begin
        best_d = d;
        winner = GID_W'(i);
      end
    end
  end

endmodule

// File: rtl/system_bus_arbiter.sv
// Round-robin arbiter sharing one system bus slave among NUM_MASTERS
// masters, with a per-transaction watchdog and a sticky timeout flag.
module system_bus_arbiter
  import system_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_MASTERS*32-1:0] m_addr,
  input  logic [NUM_MASTERS*32-1:0] m_wdata,
  input  logic [NUM_MASTERS*4-1:0]  m_be,
  input  logic [NUM_MASTERS-1:0]    m_we,
  input  logic [NUM_MASTERS-1:0]    m_req,
  output logic [31:0]               m_rdata,
  output logic [NUM_MASTERS-1:0]    m_ready,
  output logic [31:0]               s_addr,
  output logic [31:0]               s_wdata,
  output logic [3:0]                s_be,
  output logic                      s_we,
  output logic                      s_req,
  input  logic [31:0]               s_rdata,
  input  logic                      s_ready,
  output logic [GID_W-1:0]          grant_id,
  output logic                      timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e           state_q, state_d;
  logic [GID_W-1:0] grant_q, grant_d;
  logic [GID_W-1:0] last_q, last_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             terr_q, terr_d;

  logic [GID_W-1:0] winner;
  logic             any_req;
  logic             busy, timeout_hit, done;
  logic [31:0]      g_addr, g_wdata;
  logic [3:0]       g_be;
  logic             g_we;

  rr_priority_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
    .req        (m_req),
    .last_grant (last_q),
    .winner     (winner),
    .any_req    (any_req)
  );

  // s_ready takes priority over an expiring watchdog
  assign busy        = (state_q == ST_BUSY);
  assign timeout_hit = busy && !s_ready && (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign done        = busy && (s_ready || timeout_hit);

  always_comb begin
    g_addr  = '0;
    g_wdata = '0;
    g_be    = '0;
    g_we    = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q == GID_W'(i)) begin
        g_addr  = m_addr[32*i +: 32];
        g_wdata = m_wdata[32*i +: 32];
        g_be    = m_be[4*i +: 4];
        g_we    = m_we[i];
      end
    end
  end

  always_comb begin
    s_req   = busy && !timeout_hit;
    s_addr  = busy ? g_addr  : '0;
    s_wdata = busy ? g_wdata : '0;
    s_be    = busy ? g_be    : '0;
    s_we    = busy && g_we;
    m_rdata = '0;
    if (done) m_rdata = s_ready ? s_rdata : TIMEOUT_RDATA;
    for (int i = 0; i < NUM_MASTERS; i++)
      m_ready[i] = done && (grant_q == GID_W'(i));
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    terr_d  = terr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d = winner;
          wdog_d  = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (done) begin
          last_d  = grant_q;
          state_d = ST_IDLE;
          if (timeout_hit) terr_d = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= GID_W'(NUM_MASTERS - 1);
      wdog_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      terr_q  <= terr_d;
    end
  end

  assign grant_id    = grant_q;
  assign timeout_err = terr_q;

endmodule
